condlogic_it: RTL and testbench

Conditional-execution unit for the multicycle ARM datapath, extending the existing condition logic with Thumb-2-style IT blocks. It holds the NZCV flags register and evaluates each instruction's condition. It gates the PCSrc, RegWrite and MemWrite outputs. After an IT instruction, it predicates up to IT_DEPTH following instructions from a stored base condition and then/else pattern, ignoring their own Cond fields. It sits between the decoder/control FSM and the register file, memory and PC-select logic.

---
 rtl/condlogic_it.sv | 174 +++++++++++++++++
 tb/tb_condlogic_it.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/condlogic_it.sv
// condlogic_it: ARM condition logic with Thumb-2 style IT-block predication.
// Holds NZCV, evaluates the effective condition of the current instruction
// and gates PCSrc/RegWrite/MemWrite. Inside an IT block the slot condition
// comes from the stored base condition and then/else mask.
// Optional feature macro: CONDLOGIC_UNDEF_TRAP_EN (sticky trap on Cond=1111
// retiring outside an IT block; when undefined UndefErr is tied low).
module condlogic_it #(
  parameter int IT_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [3:0]                     Cond,
  input  logic [3:0]                     ALUFlags,
  input  logic [1:0]                     FlagW,
  input  logic                           PCS,
  input  logic                           RegW,
  input  logic                           MemW,
  input  logic                           InstrAdv,
  input  logic                           ITStart,
  input  logic [3:0]                     ITCond,
  input  logic [$clog2(IT_DEPTH+1)-1:0]  ITLen,
  input  logic [IT_DEPTH-1:0]            ITThen,
  output logic                           PCSrc,
  output logic                           RegWrite,
  output logic                           MemWrite,
  output logic                           CondEx,
  output logic [3:0]                     Flags,
  output logic                           ITActive,
  output logic [$clog2(IT_DEPTH+1)-1:0]  ITRemain,
  output logic                           UndefErr
);

  localparam int LW = $clog2(IT_DEPTH + 1);
  localparam int SW = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(IT_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [3:0]          flags_q, flags_d;
  logic [3:0]          it_cond_q, it_cond_d;
  logic [IT_DEPTH-1:0] it_then_q, it_then_d;
  logic [LW-1:0]       remain_q, remain_d;
  logic [SW-1:0]       slot_q, slot_d;

  logic [3:0]          eff_cond;
  logic                cond_pass;
  logic [1:0]          flag_write;
  logic [LW-1:0]       len_clamped;

  assign ITActive = (state_q == S_ACTIVE);
  assign ITRemain = remain_q;
  assign Flags    = flags_q;

  // Effective condition: the IT slot overrides the instruction's own field;
  // an else slot flips the low condition bit (the inverse ARM condition).
  always_comb begin
    eff_cond = Cond;
    if (ITActive)
      eff_cond = {it_cond_q[3:1], it_cond_q[0] ^ ~it_then_q[slot_q]};
  end

  // ARM condition decode against the registered flags; 1111 never passes.
  always_comb begin
    logic n, z, c, v, ge;
    {n, z, c, v} = flags_q;
    ge = ~(n ^ v);
    cond_pass = 1'b0;
    case (eff_cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = ~c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = c & ~z;
      4'b1001: cond_pass = ~c | z;
      4'b1010: cond_pass = ge;
      4'b1011: cond_pass = ~ge;
      4'b1100: cond_pass = ~z & ge;
      4'b1101: cond_pass = z | ~ge;
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign CondEx     = cond_pass;
  assign PCSrc      = PCS  & cond_pass;
  assign RegWrite   = RegW & cond_pass;
  assign MemWrite   = MemW & cond_pass;
  assign flag_write = FlagW & {2{cond_pass}};

  // Out-of-range lengths (0 or beyond the depth) mean a full-depth block.
  always_comb begin
    len_clamped = ITLen;
    if ((ITLen == '0) || (ITLen > DEPTH_L))
      len_clamped = DEPTH_L;
  end

  // Next-state: flag update plus IT block sequencing on each retirement.
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    it_cond_d = it_cond_q;
    it_then_d = it_then_q;
    remain_d  = remain_q;
    slot_d    = slot_q;

    if (flag_write[1]) flags_d[3:2] = ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = ALUFlags[1:0];

    if (InstrAdv) begin
      if (ITStart) begin
        // A new IT (including one nested in a live block) always reloads.
        state_d   = S_ACTIVE;
        it_cond_d = ITCond;
        it_then_d = ITThen | {{(IT_DEPTH-1){1'b0}}, 1'b1};
        remain_d  = len_clamped;
        slot_d    = '0;
      end else if (state_q == S_ACTIVE) begin
        if (PCSrc || (remain_q == LW'(1))) begin
          // Taken branch or last slot ends the block.
          state_d  = S_IDLE;
          remain_d = '0;
          slot_d   = '0;
        end else begin
          remain_d = remain_q - LW'(1);
          slot_d   = slot_q + SW'(1);
        end
      end
    end
  end

  // State registers; reset aborts any block and clears the flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      flags_q   <= 4'b0000;
      it_cond_q <= 4'b0000;
      it_then_q <= '0;
      remain_q  <= '0;
      slot_q    <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      it_cond_q <= it_cond_d;
      it_then_q <= it_then_d;
      remain_q  <= remain_d;
      slot_q    <= slot_d;
    end
  end

`ifdef CONDLOGIC_UNDEF_TRAP_EN
  logic undef_q, undef_d;

  // Sticky trap: an unpredicated instruction with Cond=1111 retired.
  always_comb begin
    undef_d = undef_q | (InstrAdv & ~ITActive & (Cond == 4'b1111));
  end

  // Trap register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) undef_q <= 1'b0;
    else       undef_q <= undef_d;
  end

  assign UndefErr = undef_q;
`else
  assign UndefErr = 1'b0;
`endif

endmodule

// File: tb/tb_condlogic_it.sv
// Bench for condlogic_it: decode vector table, hand sequences for the IT
// corner cases, then randomized traffic against a queue-based reference.
module tb_condlogic_it;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH + 1);
`ifdef CONDLOGIC_UNDEF_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0, reset;
  logic [3:0] Cond, ALUFlags, ITCond;
  logic [1:0] FlagW;
  logic PCS, RegW, MemW, InstrAdv, ITStart;
  logic [LW-1:0] ITLen;
  logic [DEPTH-1:0] ITThen;
  logic PCSrc, RegWrite, MemWrite, CondEx, ITActive, UndefErr;
  logic [3:0] Flags;
  logic [LW-1:0] ITRemain;

  int checks = 0;
  int errors = 0;

  condlogic_it #(.IT_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .InstrAdv(InstrAdv), .ITStart(ITStart),
    .ITCond(ITCond), .ITLen(ITLen), .ITThen(ITThen), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
    .ITActive(ITActive), .ITRemain(ITRemain), .UndefErr(UndefErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reset = 0; Cond = 4'hE; ALUFlags = 0; FlagW = 0; PCS = 0; RegW = 0; MemW = 0;
    InstrAdv = 0; ITStart = 0; ITCond = 0; ITLen = 0; ITThen = 0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    Cond = 4'hE; FlagW = 2'b11; ALUFlags = f; InstrAdv = 0; ITStart = 0;
    tick();
    FlagW = 2'b00;
  endtask

  task automatic start_it(input logic [3:0] c, input int len, input logic [DEPTH-1:0] th);
    InstrAdv = 1; ITStart = 1; ITCond = c; ITLen = LW'(len); ITThen = th; Cond = 4'hE;
    tick();
    ITStart = 0;
  endtask

  // Reference condition evaluation written from the condition table.
  function automatic bit pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    bit r[16];
    {n, z, cy, v} = f;
    r[0] = z;  r[1] = !z;  r[2] = cy; r[3] = !cy;
    r[4] = n;  r[5] = !n;  r[6] = v;  r[7] = !v;
    r[8] = cy && !z;       r[9] = !cy || z;
    r[10] = (n == v);      r[11] = (n != v);
    r[12] = !z && (n == v); r[13] = z || (n != v);
    r[14] = 1'b1;          r[15] = 1'b0;
    return r[c];
  endfunction

  // Reference model: the pending IT block is a queue of slot conditions.
  logic [3:0] m_flags;
  logic [3:0] m_q[$];
  bit m_undef;

  task automatic model_step(input bit ce);
    logic [1:0] fw;
    int n;
    if (reset) begin
      m_flags = 0; m_q.delete(); m_undef = 0;
      return;
    end
    fw = FlagW & {2{ce}};
    if (fw[1]) m_flags[3:2] = ALUFlags[3:2];
    if (fw[0]) m_flags[1:0] = ALUFlags[1:0];
    if (InstrAdv) begin
      if (TRAP && m_q.size() == 0 && Cond == 4'hF) m_undef = 1;
      if (ITStart) begin
        m_q.delete();
        n = int'(ITLen);
        if (n == 0 || n > DEPTH) n = DEPTH;
        for (int i = 0; i < n; i++)
          m_q.push_back((i == 0 || ITThen[i]) ? ITCond : (ITCond ^ 4'h1));
      end else if (m_q.size() != 0) begin
        if (PCS && ce) m_q.delete();
        else void'(m_q.pop_front());
      end
    end
  endtask

  typedef struct packed {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;
  vec_t vecs[14];

  initial begin
    vecs[0]  = '{4'b0100, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0100, 4'b0001, 1'b0};
    vecs[3]  = '{4'b0010, 4'b0010, 1'b1};
    vecs[4]  = '{4'b0010, 4'b1000, 1'b1};
    vecs[5]  = '{4'b0110, 4'b1000, 1'b0};
    vecs[6]  = '{4'b1000, 4'b1010, 1'b0};
    vecs[7]  = '{4'b1001, 4'b1010, 1'b1};
    vecs[8]  = '{4'b1001, 4'b1100, 1'b1};
    vecs[9]  = '{4'b1101, 4'b1101, 1'b1};
    vecs[10] = '{4'b0000, 4'b1111, 1'b0};
    vecs[11] = '{4'b0000, 4'b1110, 1'b1};
    vecs[12] = '{4'b1000, 4'b0100, 1'b1};
    vecs[13] = '{4'b0001, 4'b0110, 1'b1};

    clr();
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rst_flags", 8'(Flags), 8'h0);
    chk("rst_itactive", 8'(ITActive), 8'h0);
    chk("rst_itremain", 8'(ITRemain), 8'h0);
    chk("rst_undef", 8'(UndefErr), 8'h0);

    // Cond EQ with Z clear blocks the write; setting Z lets it through.
    Cond = 4'h0; RegW = 1; #1;
    chk("eq_z0_regwrite", 8'(RegWrite), 8'h0);
    Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b0100;
    tick();
    FlagW = 0; Cond = 4'h0; #1;
    chk("eq_z1_regwrite", 8'(RegWrite), 8'h1);

    // Decode table.
    foreach (vecs[i]) begin
      set_flags(vecs[i].flags);
      Cond = vecs[i].cond; #1;
      chk("vec_flags", 8'(Flags), 8'(vecs[i].flags));
      chk($sformatf("vec_condex_%0d", i), 8'(CondEx), 8'(vecs[i].exp));
    end

    // EQ block, then/else/then, own Cond field (NE) ignored.
    set_flags(4'b0100);
    start_it(4'h0, 3, 4'b0101);
    chk("it_active", 8'(ITActive), 8'h1);
    chk("it_remain3", 8'(ITRemain), 8'h3);
    Cond = 4'h1; RegW = 1; InstrAdv = 1; #1;
    chk("it_slot0", 8'(RegWrite), 8'h1);
    tick();
    chk("it_slot1", 8'(RegWrite), 8'h0);
    tick();
    chk("it_slot2", 8'(RegWrite), 8'h1);
    tick();
    chk("it_done_active", 8'(ITActive), 8'h0);
    chk("it_done_remain", 8'(ITRemain), 8'h0);
    chk("it_done_cond", 8'(RegWrite), 8'h0);

    // Taken branch at slot 1 leaves the block.
    RegW = 0;
    start_it(4'hE, 4, 4'b1111);
    InstrAdv = 1; tick();
    PCS = 1; #1;
    chk("br_pcsrc", 8'(PCSrc), 8'h1);
    tick();
    chk("br_active", 8'(ITActive), 8'h0);
    InstrAdv = 0; Cond = 4'hF; #1;
    chk("br_cond_governs", 8'(PCSrc), 8'h0);
    PCS = 0;

    // Nested IT at slot 1 replaces the block.
    start_it(4'h0, 4, 4'b1111);
    InstrAdv = 1; tick();
    RegW = 1; #1;
    chk("nest_pre", 8'(RegWrite), 8'h1);
    start_it(4'h1, 2, 4'b0011);
    chk("nest_remain", 8'(ITRemain), 8'h2);
    chk("nest_active", 8'(ITActive), 8'h1);
    chk("nest_newcond", 8'(RegWrite), 8'h0);

    // Reset mid-block aborts it and clears flags.
    start_it(4'h0, 4, 4'b1111);
    InstrAdv = 1; tick(); tick();
    chk("rmid_remain", 8'(ITRemain), 8'h2);
    reset = 1; tick(); reset = 0; #1;
    chk("rmid_active", 8'(ITActive), 8'h0);
    chk("rmid_flags", 8'(Flags), 8'h0);
    Cond = 4'hE; #1;
    chk("rmid_al", 8'(CondEx), 8'h1);

    // Undefined-condition trap.
    Cond = 4'hF; InstrAdv = 1; #1;
    chk("undef_condex", 8'(CondEx), 8'h0);
    tick();
    chk("undef_set", 8'(UndefErr), 8'(TRAP));
    Cond = 4'h0; tick(); tick();
    chk("undef_hold", 8'(UndefErr), 8'(TRAP));
    reset = 1; tick(); reset = 0;
    start_it(4'hE, 4, 4'b1111);
    Cond = 4'hF; InstrAdv = 1; tick();
    chk("undef_inblock", 8'(UndefErr), 8'h0);

    // Randomized traffic against the reference model.
    clr();
    for (int k = 0; k < 4000; k++) begin
      logic [3:0] ec;
      bit ce;
      reset    = (k == 0) || ($urandom_range(199) == 0);
      Cond     = 4'($urandom);
      ALUFlags = 4'($urandom);
      FlagW    = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
      PCS      = ($urandom_range(5) == 0);
      RegW     = 1'($urandom);
      MemW     = 1'($urandom);
      InstrAdv = ($urandom_range(2) != 0);
      ITStart  = ($urandom_range(6) == 0);
      ITCond   = 4'($urandom);
      ITLen    = LW'($urandom);
      ITThen   = DEPTH'($urandom);
      #2;
      if (k != 0) begin
        ec = (m_q.size() != 0) ? m_q[0] : Cond;
        ce = pass(ec, m_flags);
        chk("rnd_condex", 8'(CondEx), 8'(ce));
        chk("rnd_pcsrc", 8'(PCSrc), 8'(PCS & ce));
        chk("rnd_regwrite", 8'(RegWrite), 8'(RegW & ce));
        chk("rnd_memwrite", 8'(MemWrite), 8'(MemW & ce));
        chk("rnd_flags", 8'(Flags), 8'(m_flags));
        chk("rnd_itactive", 8'(ITActive), 8'(m_q.size() != 0));
        chk("rnd_itremain", 8'(ITRemain), 8'(m_q.size()));
        chk("rnd_undef", 8'(UndefErr), 8'(m_undef));
      end else begin
        ce = 1'b0;
      end
      model_step(ce);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
